// File: rtl/maxpool_2x2.sv
// rtl/maxpool_2x2.sv - streaming 2x2 stride-2 max-pool stage with a half-row line buffer.
// Top-row horizontal maxima are parked per column pair and merged with the bottom row on odd rows.
module maxpool_2x2 #(
   parameter int IMG_W = 210,
   parameter int IMG_H = 210,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] pxl_in,
   input  logic          valid_in,
   output logic [DW-1:0] pxl_out,
   output logic          valid_out,
   output logic          frame_done
);

   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int LB_D = IMG_W / 2;
   localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [DW-1:0] hold_q, hold_d;
   logic [DW-1:0] pxl_out_q, pxl_out_d;
   logic          valid_out_q, valid_out_d;
   logic          frame_done_q, frame_done_d;

   logic [DW-1:0] linebuf [LB_D];

   logic          last_col, last_row, lb_we, emit;
   logic [AW-1:0] lb_addr;
   logic [DW-1:0] pair_max, lb_rd, win_max;

   always_comb begin
      last_col = (col_q == CW'(IMG_W - 1));
      last_row = (row_q == RW'(IMG_H - 1));
      lb_addr  = AW'(col_q >> 1);
      pair_max = (pxl_in > hold_q) ? pxl_in : hold_q;
      lb_rd    = linebuf[lb_addr];
      win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
      // A trailing odd column sits on an even index, so it never pairs or writes.
      lb_we    = valid_in & col_q[0] & ~row_q[0];
      emit     = valid_in & col_q[0] &  row_q[0];
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      valid_out_d  = emit;
      pxl_out_d    = emit ? win_max : pxl_out_q;
      frame_done_d = valid_in & last_col & last_row;
      if (valid_in) begin
         if (!col_q[0]) begin
            hold_d = pxl_in;
         end
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         pxl_out_q    <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         pxl_out_q    <= pxl_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Contents are rewritten on every even row before being read, so no reset is needed.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         linebuf[lb_addr] <= pair_max;
      end
   end

   assign pxl_out    = pxl_out_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule
